lfsr_gen: RTL
=============

LFSR_GEN -- requirements
Module: lfsr_gen

Interface
REQ-001 SHALL have parameter WIDTH, default 4: state width in bits, legal range 3..32.
REQ-002 SHALL have parameter TAPS, default 4'b1100: feedback tap mask over state bits, WIDTH bits wide.
REQ-003 SHALL have parameter RESET_SEED, default 1 (4'b0001): state and seed-register value after reset; must be nonzero.
REQ-004 SHALL have one clock and an asynchronous, active-high reset.
REQ-005 SHALL have port clkslow, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-007 SHALL have port load, input, 1 bit: load seed into state and the seed register.
REQ-008 SHALL have port seed, input, WIDTH bits: seed value, sampled only when load=1.
REQ-009 SHALL have port en, input, 1 bit: advance the LFSR one step.
REQ-010 SHALL have port q, output, WIDTH bits: current LFSR state, registered.
REQ-011 SHALL have port bit_out, output, 1 bit: serial output, equal to q[WIDTH-1].
REQ-012 SHALL have port wrap, output, 1 bit: registered one-cycle pulse, sequence returned to seed.
REQ-013 SHALL have port period, output, WIDTH bits: step count of the last completed cycle.
REQ-014 SHALL have port zero_fix, output, 1 bit: registered one-cycle pulse, zero seed was substituted.

Function
REQ-015 SHALL compute feedback fb = XOR-reduce(q & TAPS).
REQ-016 SHALL, on a step, update q to next = {q[WIDTH-2:0], fb}, i.e. shift toward the MSB with fb entering bit 0.
REQ-017 SHALL hold internal registers seed_reg (WIDTH bits) and step_cnt (WIDTH bits).
REQ-018 SHALL, when load=1, set q and seed_reg to seed and clear step_cnt on the next edge, with zero latency to q.
REQ-019 SHALL, when load=1 and seed==0, load 1 instead of 0 into q and seed_reg, and pulse zero_fix=1 for the following cycle; zero_fix is 0 otherwise.
REQ-020 SHALL give load priority over en when both are 1 in the same cycle: the load is performed and no step occurs.
REQ-021 SHALL, when en=1 and load=0, step q per REQ-016.
REQ-022 SHALL, on a step where next != seed_reg, increment step_cnt by 1.
REQ-023 SHALL, on a step where next == seed_reg, assert wrap=1 in the following cycle, set period to step_cnt+1 (modulo 2^WIDTH), and clear step_cnt.
REQ-024 SHALL keep wrap at 0 in all other cycles.
REQ-025 SHALL hold q, step_cnt, period and seed_reg unchanged when en=0 and load=0.
REQ-026 SHALL let period retain its last value across later loads, updating only on a wrap.
REQ-027 SHALL, when no wrap has occurred since reset, keep period at 0.
REQ-028 SHALL make the outputs independent of combinational input-to-output paths; all outputs except bit_out are registered, and bit_out is a wire from q.
REQ-029 SHALL never reach q==0 from any reachable state; the all-zero lock-up state is unreachable by construction.

Reset
REQ-030 SHALL, while rst=1, immediately and asynchronously force q=RESET_SEED, seed_reg=RESET_SEED, step_cnt=0, period=0, wrap=0, zero_fix=0, regardless of clkslow.
REQ-031 SHALL, when rst is asserted mid-sequence, abandon any in-flight step or load; the first edge after rst deasserts obeys REQ-018..REQ-025.

Verification
REQ-032 SHALL cover the default-parameter sequence: reset, then en=1 for 15 cycles -> q = 0010,0100,1001,0011,0110,1101,1010,0101,1011,0111,1111,1110,1100,1000,0001; wrap=1 only in the cycle after the 15th step; period=15.
REQ-033 SHALL cover load of a nonzero seed: load=1 with seed=4'b1010, then en=1 for 3 cycles -> q = 1010,0101,1011,0111; step_cnt counts 1,2,3; no wrap.
REQ-034 SHALL cover zero-seed substitution: load=1 with seed=0 -> q=0001 and zero_fix=1 for exactly one cycle; the next en step gives q=0010.
REQ-035 SHALL cover the load+en collision: load=1 and en=1 with seed=4'b0110 -> q=0110, not 1101; step_cnt=0.
REQ-036 SHALL cover the enable hold: en=0 for 5 cycles mid-sequence -> q, period and wrap unchanged, with wrap=0.
REQ-037 SHALL cover asynchronous reset mid-run: assert rst between edges after 7 steps -> q=0001 and period=0 before the next clkslow edge; the sequence restarts per REQ-032.

Source files
------------

// File: rtl/lfsr_gen.sv
// Fibonacci-style LFSR with loadable seed, zero-seed substitution and cycle-period measurement.
// The state shifts toward the MSB and the XOR of the tapped bits enters bit 0.
module lfsr_gen #(
    parameter int unsigned           WIDTH      = 4,
    parameter logic [WIDTH-1:0]      TAPS       = 4'b1100,
    parameter logic [WIDTH-1:0]      RESET_SEED = {{(WIDTH-1){1'b0}}, 1'b1}
) (
    input  logic             clkslow,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] seed,
    input  logic             en,
    output logic [WIDTH-1:0] q,
    output logic             bit_out,
    output logic             wrap,
    output logic [WIDTH-1:0] period,
    output logic             zero_fix
);

    logic [WIDTH-1:0] seed_reg;
    logic [WIDTH-1:0] step_cnt;
    logic             fb;
    logic [WIDTH-1:0] nxt;
    logic             seed_zero;
    logic [WIDTH-1:0] seed_fixed;

    assign fb         = ^(q & TAPS);
    assign nxt        = {q[WIDTH-2:0], fb};
    assign seed_zero  = (seed == '0);
    // An all-zero seed would lock the register up, so it is replaced by 1.
    assign seed_fixed = seed_zero ? {{(WIDTH-1){1'b0}}, 1'b1} : seed;
    assign bit_out    = q[WIDTH-1];

    always_ff @(posedge clkslow or posedge rst) begin
        if (rst) begin
            q        <= RESET_SEED;
            seed_reg <= RESET_SEED;
            step_cnt <= '0;
            period   <= '0;
            wrap     <= 1'b0;
            zero_fix <= 1'b0;
        end else begin
            wrap     <= 1'b0;
            zero_fix <= 1'b0;
            if (load) begin
                q        <= seed_fixed;
                seed_reg <= seed_fixed;
                step_cnt <= '0;
                zero_fix <= seed_zero;
            end else if (en) begin
                q <= nxt;
                // Returning to the seed closes a cycle; period counts the closing step too.
                if (nxt == seed_reg) begin
                    wrap     <= 1'b1;
                    period   <= step_cnt + 1'b1;
                    step_cnt <= '0;
                end else begin
                    step_cnt <= step_cnt + 1'b1;
                end
            end
        end
    end

endmodule
